// File: rtl/spi_master_multi.sv
// SPI master: per-transfer CPOL/CPHA, one-hot active-low slave select, MSB-first words.
// Optional macro SPI_LOOPBACK_EN adds a loopback input that feeds MOSI back into the rx path.
module spi_master_multi #(
  parameter int WORD_LENGTH      = 8,
  parameter int CLK_PER_HALF_BIT = 4,
  parameter int NUM_SLAVES       = 2,
  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   apb_ready,
  input  logic                   cpol,
  input  logic                   cpha,
  input  logic [SEL_W-1:0]       ss_sel,
  input  logic [WORD_LENGTH-1:0] WDATA,
`ifdef SPI_LOOPBACK_EN
  input  logic                   loopback,
`endif
  output logic [WORD_LENGTH-1:0] RDATA,
  output logic                   rx_data_valid,
  output logic                   SPI_status_RDY_BSYbar,
  output logic                   SCLK,
  output logic                   MOSI,
  input  logic                   MISO,
  output logic [NUM_SLAVES-1:0]  SSbar
);

  localparam int HW = $clog2(CLK_PER_HALF_BIT);
  localparam int EW = $clog2(2 * WORD_LENGTH);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} state_t;

  state_t                 state;
  logic [HW-1:0]          hcnt;
  logic [EW-1:0]          ecnt;
  logic [WORD_LENGTH-1:0] tx_sr, rx_sr;
  logic                   cpol_q, cpha_q;
  logic [NUM_SLAVES-1:0]  sel_mask;
  logic                   rx_bit, half_end, lead, last_edge;

  // Out-of-range selects leave every line deasserted.
  always_comb begin
    sel_mask = '1;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (ss_sel == SEL_W'(i)) sel_mask[i] = 1'b0;
`ifdef SPI_LOOPBACK_EN
    if (loopback) sel_mask = '1;
`endif
  end

`ifdef SPI_LOOPBACK_EN
  logic lb_q;
  always_ff @(posedge clk) begin
    if (rst)                            lb_q <= 1'b0;
    else if (state == IDLE && apb_ready) lb_q <= loopback;
  end
  assign rx_bit = lb_q ? MOSI : MISO;
`else
  assign rx_bit = MISO;
`endif

  assign half_end  = (hcnt == HW'(CLK_PER_HALF_BIT - 1));
  assign lead      = ~ecnt[0];
  assign last_edge = (ecnt == EW'(2 * WORD_LENGTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= IDLE;
      hcnt                  <= '0;
      ecnt                  <= '0;
      tx_sr                 <= '0;
      rx_sr                 <= '0;
      cpol_q                <= 1'b0;
      cpha_q                <= 1'b0;
      RDATA                 <= '0;
      rx_data_valid         <= 1'b0;
      SPI_status_RDY_BSYbar <= 1'b1;
      SCLK                  <= 1'b0;
      MOSI                  <= 1'b0;
      SSbar                 <= '1;
    end else begin
      rx_data_valid <= 1'b0;
      case (state)
        IDLE: begin
          SCLK                  <= cpol;
          MOSI                  <= 1'b0;
          SSbar                 <= '1;
          SPI_status_RDY_BSYbar <= 1'b1;
          if (apb_ready) begin
            tx_sr                 <= WDATA;
            rx_sr                 <= '0;
            cpol_q                <= cpol;
            cpha_q                <= cpha;
            MOSI                  <= WDATA[WORD_LENGTH-1];
            SSbar                 <= sel_mask;
            hcnt                  <= '0;
            ecnt                  <= '0;
            SPI_status_RDY_BSYbar <= 1'b0;
            state                 <= SETUP;
          end
        end
        SETUP: begin
          if (half_end) begin
            hcnt  <= '0;
            state <= XFER;
          end else hcnt <= hcnt + 1'b1;
        end
        XFER: begin
          if (half_end) begin
            hcnt <= '0;
            SCLK <= ~SCLK;
            ecnt <= ecnt + 1'b1;
            // Sample on leading edges for cpha=0, trailing for cpha=1; shift on the other edge,
            // skipping the first leading (cpha=1) or final trailing (cpha=0) edge.
            if (lead ^ cpha_q)
              rx_sr <= {rx_sr[WORD_LENGTH-2:0], rx_bit};
            else if (cpha_q ? (ecnt != '0) : !last_edge) begin
              tx_sr <= {tx_sr[WORD_LENGTH-2:0], 1'b0};
              MOSI  <= tx_sr[WORD_LENGTH-2];
            end
            if (last_edge) begin
              ecnt  <= '0;
              SCLK  <= cpol_q;
              state <= HOLD;
            end
          end else hcnt <= hcnt + 1'b1;
        end
        HOLD: begin
          if (half_end) begin
            hcnt          <= '0;
            SSbar         <= '1;
            RDATA         <= rx_sr;
            rx_data_valid <= 1'b1;
            state         <= DONE;
          end else hcnt <= hcnt + 1'b1;
        end
        DONE: begin
          SCLK                  <= cpol;
          MOSI                  <= 1'b0;
          SPI_status_RDY_BSYbar <= 1'b1;
          state                 <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi: three instances (default, 16-bit fast, 3 slaves).
// Cycle n below = the n-th rising edge after the accept edge, at which a consumer sees the output.
module tb_spi_master_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int n_chk = 0;
  int n_fail = 0;

  // u0: defaults W=8, H=4, N=2
  logic       ar0, cpol0, cpha0, v0, st0, sclk0, mosi0, miso0, lb0;
  logic [0:0] sel0;
  logic [7:0] wd0, rd0;
  logic [1:0] ss0;
  // u1: W=16, H=2
  logic        ar1, cpol1, cpha1, v1, st1, sclk1, mosi1, lb1;
  wire logic   miso1;
  logic [0:0]  sel1;
  logic [15:0] wd1, rd1;
  logic [1:0]  ss1;
  // u2: N=3, H=2
  logic       ar2, cpol2, cpha2, v2, st2, sclk2, mosi2, lb2;
  logic [1:0] sel2;
  logic [7:0] wd2, rd2;
  logic [2:0] ss2;

  spi_master_multi u0 (
    .clk(clk), .rst(rst), .apb_ready(ar0), .cpol(cpol0), .cpha(cpha0), .ss_sel(sel0), .WDATA(wd0),
`ifdef SPI_LOOPBACK_EN
    .loopback(lb0),
`endif
    .RDATA(rd0), .rx_data_valid(v0), .SPI_status_RDY_BSYbar(st0), .SCLK(sclk0), .MOSI(mosi0),
    .MISO(miso0), .SSbar(ss0));

  spi_master_multi #(.WORD_LENGTH(16), .CLK_PER_HALF_BIT(2)) u1 (
    .clk(clk), .rst(rst), .apb_ready(ar1), .cpol(cpol1), .cpha(cpha1), .ss_sel(sel1), .WDATA(wd1),
`ifdef SPI_LOOPBACK_EN
    .loopback(lb1),
`endif
    .RDATA(rd1), .rx_data_valid(v1), .SPI_status_RDY_BSYbar(st1), .SCLK(sclk1), .MOSI(mosi1),
    .MISO(miso1), .SSbar(ss1));

  spi_master_multi #(.NUM_SLAVES(3), .CLK_PER_HALF_BIT(2)) u2 (
    .clk(clk), .rst(rst), .apb_ready(ar2), .cpol(cpol2), .cpha(cpha2), .ss_sel(sel2), .WDATA(wd2),
`ifdef SPI_LOOPBACK_EN
    .loopback(lb2),
`endif
    .RDATA(rd2), .rx_data_valid(v2), .SPI_status_RDY_BSYbar(st2), .SCLK(sclk2), .MOSI(mosi2),
    .MISO(1'b1), .SSbar(ss2));

  // Loopback build proves the internal path by grounding MISO; otherwise MISO is wired to MOSI.
`ifdef SPI_LOOPBACK_EN
  assign miso1 = 1'b0;
`else
  assign miso1 = mosi1;
`endif

  // Slave model for u0: reloads while master idle, acts on observed SCLK transitions.
  logic [7:0] slv_word, s_sh, s_rx;
  logic       slv_cpha, sclk_d;
  int         s_edges;
  always @(negedge clk) begin
    sclk_d <= sclk0;
    if (st0) begin
      s_sh    <= slv_word;
      s_rx    <= '0;
      s_edges <= 0;
      miso0   <= slv_word[7];
    end else if (sclk0 !== sclk_d) begin
      s_edges <= s_edges + 1;
      if ((s_edges % 2 == 0) != slv_cpha) s_rx <= {s_rx[6:0], mosi0};
      else if (slv_cpha) begin
        miso0 <= s_sh[7];
        s_sh  <= {s_sh[6:0], 1'b0};
      end else begin
        miso0 <= s_sh[6];
        s_sh  <= {s_sh[6:0], 1'b0};
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic xfer0(input logic pol, input logic pha, input logic [0:0] sel, input logic [7:0] wd,
                       input logic [7:0] sw, output int n, output logic [1:0] seen,
                       output logic sclk_before, output logic busy);
    cpol0 = pol; cpha0 = pha; sel0 = sel; wd0 = wd; slv_word = sw; slv_cpha = pha;
    repeat (3) @(negedge clk);
    sclk_before = sclk0;
    ar0 = 1'b1;
    @(negedge clk);
    ar0 = 1'b0;
    busy = st0;
    n = 1;
    seen = ~ss0;
    while (!v0 && n < 300) begin
      @(negedge clk);
      n++;
      seen |= ~ss0;
    end
    if (!v0) n = -1;
  endtask

  int         n, gap, edges, pulses, first;
  logic [1:0] seen;
  logic [2:0] seen3;
  logic       sb, busy, pol, pha, prev;

  initial begin
    rst = 1'b1;
    {ar0, ar1, ar2, lb0, lb2} = '0;
    lb1 = 1'b1;
    {cpol0, cpha0, cpol1, cpha1, cpol2, cpha2} = '0;
    sel0 = '0; sel1 = '0; sel2 = '0;
    wd0 = '0; wd1 = '0; wd2 = '0;
    slv_word = '0; slv_cpha = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdata", 32'(rd0), 32'h0);
    chk("rst_valid", 32'(v0), 32'h0);
    chk("rst_status", 32'(st0), 32'h1);
    chk("rst_sclk", 32'(sclk0), 32'h0);
    chk("rst_mosi", 32'(mosi0), 32'h0);
    chk("rst_ssbar", 32'(ss0), 32'h3);
    chk("rst_ssbar3", 32'(ss2), 32'h7);
    rst = 1'b0;

    // Reset on the 5th SCLK edge of a live transfer.
    sel0 = 1'b1; wd0 = 8'hA5; slv_word = 8'h3C;
    repeat (2) @(negedge clk);
    ar0 = 1'b1;
    @(negedge clk);
    ar0 = 1'b0;
    edges = 0; prev = sclk0; n = 0;
    while (edges < 5 && n < 300) begin
      @(negedge clk);
      n++;
      if (sclk0 !== prev) edges++;
      prev = sclk0;
    end
    chk("mid_edges_seen", 32'(edges), 32'd5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_status", 32'(st0), 32'h1);
    chk("mid_ssbar", 32'(ss0), 32'h3);
    chk("mid_valid", 32'(v0), 32'h0);
    chk("mid_rdata", 32'(rd0), 32'h0);
    pulses = 0;
    repeat (100) begin
      @(negedge clk);
      if (v0) pulses++;
    end
    chk("mid_no_pulse", 32'(pulses), 32'd0);

    // Basic transfer: A5 out, 3C back, slave 1.
    xfer0(1'b0, 1'b0, 1'b1, 8'hA5, 8'h3C, n, seen, sb, busy);
    chk("basic_cycle", 32'(n), 32'd73);
    chk("basic_rdata", 32'(rd0), 32'h3C);
    chk("basic_mosi_bits", 32'(s_rx), 32'hA5);
    chk("basic_ss_seen", 32'(seen), 32'h2);
    chk("basic_busy", 32'(busy), 32'h0);
    chk("basic_ss_done", 32'(ss0), 32'h3);
    chk("basic_sclk_idle", 32'(sb), 32'h0);

    // All four modes, slave echoes 0x81.
    for (int m = 0; m < 4; m++) begin
      pol = m[1]; pha = m[0];
      xfer0(pol, pha, 1'b0, 8'h81, 8'h81, n, seen, sb, busy);
      chk($sformatf("mode%0d_cycle", m), 32'(n), 32'd73);
      chk($sformatf("mode%0d_rdata", m), 32'(rd0), 32'h81);
      chk($sformatf("mode%0d_slave_rx", m), 32'(s_rx), 32'h81);
      chk($sformatf("mode%0d_sclk_before", m), 32'(sb), 32'(pol));
      @(negedge clk);
      chk($sformatf("mode%0d_sclk_after", m), 32'(sclk0), 32'(pol));
    end

    // apb_ready held high: exactly one IDLE cycle between transfers.
    cpol0 = 1'b0; cpha0 = 1'b0; slv_cpha = 1'b0; sel0 = 1'b1; wd0 = 8'hA5; slv_word = 8'h3C;
    repeat (3) @(negedge clk);
    ar0 = 1'b1;
    @(negedge clk);
    n = 1;
    while (!v0 && n < 300) begin @(negedge clk); n++; end
    chk("b2b_cycle1", 32'(n), 32'd73);
    chk("b2b_rdata1", 32'(rd0), 32'h3C);
    gap = 0;
    @(negedge clk);
    while (st0 && gap < 10) begin gap++; @(negedge clk); end
    chk("b2b_gap", 32'(gap), 32'd1);
    n = 1;
    while (!v0 && n < 300) begin @(negedge clk); n++; end
    ar0 = 1'b0;
    chk("b2b_cycle2", 32'(n), 32'd73);
    chk("b2b_rdata2", 32'(rd0), 32'h3C);
    repeat (3) @(negedge clk);
    chk("b2b_idle_after", 32'(st0), 32'h1);

    // 16-bit word, half-bit of 2 clocks.
    wd1 = 16'hBEEF;
    repeat (2) @(negedge clk);
    ar1 = 1'b1;
    @(negedge clk);
    ar1 = 1'b0;
    n = 1; seen = ~ss1;
    while (!v1 && n < 300) begin @(negedge clk); n++; seen |= ~ss1; end
    chk("w16_cycle", 32'(n), 32'd69);
    chk("w16_rdata", 32'(rd1), 32'hBEEF);
`ifdef SPI_LOOPBACK_EN
    chk("w16_ss_seen", 32'(seen), 32'h0);
`else
    chk("w16_ss_seen", 32'(seen), 32'h1);
`endif

    // Out-of-range select on a 3-slave master.
    sel2 = 2'd3; wd2 = 8'h5A;
    repeat (2) @(negedge clk);
    ar2 = 1'b1;
    @(negedge clk);
    ar2 = 1'b0;
    pulses = 0; first = 0; seen3 = '0;
    for (int c = 1; c <= 60; c++) begin
      if (c > 1) @(negedge clk);
      seen3 |= ~ss2;
      if (v2) begin
        pulses++;
        if (first == 0) first = c;
      end
    end
    chk("oor_cycle", 32'(first), 32'd37);
    chk("oor_pulses", 32'(pulses), 32'd1);
    chk("oor_ss_seen", 32'(seen3), 32'h0);
    chk("oor_rdata", 32'(rd2), 32'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master_multi.md
SPI_MASTER_MULTI -- requirements
Module: spi_master_multi

Interface
REQ-001 SHALL have parameter WORD_LENGTH, default 8, bits per transfer (>=2).
REQ-002 SHALL have parameter CLK_PER_HALF_BIT, default 4, clk cycles per SCLK half-period (>=2).
REQ-003 SHALL have parameter NUM_SLAVES, default 2, number of slave-select lines (>=1); SEL_W = max(1, $clog2(NUM_SLAVES)).
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port apb_ready, input, 1, transfer start request, sampled only in IDLE.
REQ-007 SHALL have port cpol, input, 1, SCLK idle level, latched at accept.
REQ-008 SHALL have port cpha, input, 1, 0 = sample on leading edge, 1 = sample on trailing edge; latched at accept.
REQ-009 SHALL have port ss_sel, input, SEL_W, target slave index, latched at accept.
REQ-010 SHALL have port WDATA, input, WORD_LENGTH, transmit word, latched at accept.
REQ-011 SHALL have port RDATA, output, WORD_LENGTH, last received word.
REQ-012 SHALL have port rx_data_valid, output, 1, one-cycle pulse when RDATA updates.
REQ-013 SHALL have port SPI_status_RDY_BSYbar, output, 1, 1 = IDLE, 0 = busy.
REQ-014 SHALL have port SCLK, output, 1, serial clock.
REQ-015 SHALL have port MOSI, output, 1, serial data out, MSB first.
REQ-016 SHALL have port MISO, input, 1, serial data in, MSB first.
REQ-017 SHALL have port SSbar, output, NUM_SLAVES, active-low slave selects.

Function
REQ-018 SHALL implement the FSM IDLE -> SETUP -> XFER -> HOLD -> DONE -> IDLE.
REQ-019 In IDLE, apb_ready=1 SHALL be accepted: latch WDATA into tx shift register, latch cpol/cpha/ss_sel, and go to SETUP on the next edge.
REQ-020 apb_ready outside IDLE, including in DONE, SHALL be ignored; a back-to-back request is accepted in the IDLE cycle after DONE.
REQ-021 In IDLE, SCLK SHALL be registered to the live cpol input, SSbar SHALL be all ones, and MOSI SHALL be 0.
REQ-022 SETUP SHALL last CLK_PER_HALF_BIT cycles with SSbar[ss_sel]=0, SCLK=cpol, and MOSI=WDATA MSB.
REQ-023 XFER SHALL toggle SCLK every CLK_PER_HALF_BIT cycles for exactly 2*WORD_LENGTH edges; odd-numbered edges are leading, even-numbered edges are trailing.
REQ-024 With cpha=0, MISO SHALL be sampled on leading edges and MOSI SHALL shift to the next bit on trailing edges 1..WORD_LENGTH-1.
REQ-025 With cpha=1, MOSI SHALL shift on leading edges (first leading edge drives the MSB) and MISO SHALL be sampled on trailing edges.
REQ-026 HOLD SHALL last CLK_PER_HALF_BIT cycles with SCLK=cpol and SSbar still asserted.
REQ-027 DONE SHALL last 1 cycle: SSbar all ones, RDATA loaded from the rx shift register, rx_data_valid=1.
REQ-028 rx_data_valid SHALL be high exactly (2*WORD_LENGTH+2)*CLK_PER_HALF_BIT+1 cycles after the accept edge.
REQ-029 SPI_status_RDY_BSYbar SHALL be 0 from the cycle after accept through DONE inclusive.
REQ-030 RDATA SHALL hold its value until the next DONE.
REQ-031 If ss_sel >= NUM_SLAVES, the transfer SHALL still run with full timing and RDATA update, but no SSbar line asserts.
REQ-032 Half-bit and edge counters SHALL be sized by $clog2 of their maximum count and SHALL never wrap within a transfer.

Reset
REQ-033 rst=1 at a clk edge SHALL force IDLE in any state, including mid-transfer, with no rx_data_valid pulse.
REQ-034 Reset values: RDATA=0, rx_data_valid=0, SPI_status_RDY_BSYbar=1, SCLK=0, MOSI=0, SSbar all ones, all counters and shift registers 0.

Configuration
REQ-035 Macro SPI_LOOPBACK_EN defined SHALL add input port loopback (1 bit, latched at accept); when latched 1, the rx path samples the internal MOSI instead of MISO, and SSbar stays all ones for that transfer.
REQ-036 Without SPI_LOOPBACK_EN, the loopback port and logic SHALL be absent and the rx path always samples MISO.

Verification
REQ-037 Defaults; cpol=0, cpha=0, ss_sel=1, WDATA=0xA5, slave model returns 0x3C -> MOSI bits 1,0,1,0,0,1,0,1; RDATA=0x3C; rx_data_valid at cycle 73 after accept; only SSbar[1] goes low.
REQ-038 All four cpol/cpha modes, WDATA=0x81, slave echoes in the same mode -> RDATA=0x81; SCLK idles at cpol before and after each transfer.
REQ-039 apb_ready held high continuously -> transfers separated by exactly one IDLE cycle; no request accepted during the busy period.
REQ-040 rst pulsed on the 5th SCLK edge -> next cycle IDLE, SSbar=all ones, status=1, no rx_data_valid, RDATA unchanged at 0.
REQ-041 WORD_LENGTH=16, CLK_PER_HALF_BIT=2, WDATA=0xBEEF, SPI_LOOPBACK_EN defined with loopback=1 -> RDATA=0xBEEF, SSbar never asserts, valid at cycle 69.
REQ-042 NUM_SLAVES=3, ss_sel=3 -> full-length transfer, SSbar=3'b111 throughout, rx_data_valid pulses once.
